ternary_mem_ctrl: RTL and testbench

//  Request/response front-end for the 27-trit ternary SRAM wrapper: takes CPU load/store requests

---
 rtl/ternary_pkg.sv | 38 +++
 rtl/ternary_tryte_merge.sv | 24 ++
 rtl/ternary_mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ternary_mem_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// rtl/ternary_pkg.sv - shared trit encodings, word/request types and invalid-trit helper
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_ZERO    = 2'b00;
    localparam trit_t T_POS_ONE = 2'b01;
    localparam trit_t T_NEG_ONE = 2'b10;
    localparam trit_t T_INVALID = 2'b11;

    localparam int TRYTE_W        = 9;
    localparam int DEF_TRIT_WIDTH = 27;
    localparam int DEF_ADDR_BITS  = 8;
    localparam int DEF_TRYTES     = DEF_TRIT_WIDTH / TRYTE_W;
    // Widest word the helper below can screen; narrower words are zero-extended (T_ZERO).
    localparam int MAX_TRITS      = 81;

    typedef trit_t [DEF_TRIT_WIDTH-1:0] word_t;

    typedef struct packed {
        logic [DEF_ADDR_BITS-1:0] addr;
        logic                     we;
        logic [DEF_TRYTES-1:0]    tmask;
        word_t                    wdata;
    } mem_req_t;

    function automatic logic has_invalid_trit(input logic [2*MAX_TRITS-1:0] word);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < MAX_TRITS; i++) begin
            if (word[2*i +: 2] == T_INVALID) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/ternary_tryte_merge.sv
// rtl/ternary_tryte_merge.sv - per-tryte merge of new and old words with invalid-trit flag
module ternary_tryte_merge
    import ternary_pkg::*;
#(
    parameter int TRIT_WIDTH = DEF_TRIT_WIDTH
) (
    input  trit_t [TRIT_WIDTH-1:0]         new_i,
    input  trit_t [TRIT_WIDTH-1:0]         old_i,
    input  logic  [TRIT_WIDTH/TRYTE_W-1:0] tmask_i,
    output trit_t [TRIT_WIDTH-1:0]         merged_o,
    output logic                           invalid_o
);

    always_comb begin
        merged_o = '0;
        for (int i = 0; i < TRIT_WIDTH; i++) begin
            merged_o[i] = tmask_i[i / TRYTE_W] ? new_i[i] : old_i[i];
        end
    end

    // Preserved trytes are screened too: a corrupt old tryte must not be rewritten silently.
    assign invalid_o = has_invalid_trit((2*MAX_TRITS)'(merged_o));

endmodule

// File: rtl/ternary_mem_ctrl.sv
// rtl/ternary_mem_ctrl.sv - load/store front-end for the ternary SRAM wrapper with tryte RMW
module ternary_mem_ctrl
    import ternary_pkg::*;
#(
    parameter int TRIT_WIDTH = DEF_TRIT_WIDTH,
    parameter int DEPTH      = 256,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int ERRCNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic  [ADDR_BITS-1:0]          req_addr,
    input  logic                           req_we,
    input  logic  [TRIT_WIDTH/TRYTE_W-1:0] req_tmask,
    input  trit_t [TRIT_WIDTH-1:0]         req_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output trit_t [TRIT_WIDTH-1:0]         rsp_rdata,
    output logic                           rsp_err,
    output logic  [ADDR_BITS-1:0]          mem_addr,
    output logic                           mem_we,
    output logic                           mem_re,
    output logic                           mem_ce,
    output trit_t [TRIT_WIDTH-1:0]         mem_wdata,
    input  trit_t [TRIT_WIDTH-1:0]         mem_rdata,
    output logic  [ERRCNT_W-1:0]           err_count
);

    typedef enum logic [1:0] {IDLE, RD_CAP, RMW_WR} state_e;

    state_e                  state_q, state_d;
    mem_req_t                req_q, req_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    trit_t [TRIT_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [ERRCNT_W-1:0]     err_count_q, err_count_d;

    logic                    accept;
    logic                    addr_oor;
    logic                    wdata_bad;
    logic                    rdata_bad;
    logic                    merge_bad;
    trit_t [TRIT_WIDTH-1:0]  merged;

    assign req_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign addr_oor  = 32'(req_addr) >= 32'(DEPTH);
    assign wdata_bad = has_invalid_trit((2*MAX_TRITS)'(req_wdata));
    assign rdata_bad = has_invalid_trit((2*MAX_TRITS)'(mem_rdata));

    ternary_tryte_merge #(.TRIT_WIDTH(TRIT_WIDTH)) u_merge (
        .new_i     (req_q.wdata),
        .old_i     (mem_rdata),
        .tmask_i   (req_q.tmask),
        .merged_o  (merged),
        .invalid_o (merge_bad)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.addr  = req_addr;
                    req_d.we    = req_we;
                    req_d.tmask = req_tmask;
                    req_d.wdata = req_wdata;
                    if (addr_oor) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (!req_we) begin
                        mem_ce   = 1'b1;
                        mem_re   = 1'b1;
                        mem_addr = req_addr;
                        state_d  = RD_CAP;
                    end else if (&req_tmask) begin
                        mem_ce      = !wdata_bad;
                        mem_we      = !wdata_bad;
                        mem_addr    = req_addr;
                        mem_wdata   = req_wdata;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = wdata_bad;
                        rsp_rdata_d = '0;
                    end else if (req_tmask == '0) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = '0;
                    end else begin
                        // Partial mask: fetch the old word, merge next cycle.
                        mem_ce   = 1'b1;
                        mem_re   = 1'b1;
                        mem_addr = req_addr;
                        state_d  = RMW_WR;
                    end
                end
            end
            RD_CAP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = rdata_bad;
                rsp_rdata_d = mem_rdata;
                state_d     = IDLE;
            end
            RMW_WR: begin
                if (!merge_bad && req_q.we) begin
                    mem_ce    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = req_q.addr;
                    mem_wdata = merged;
                end
                rsp_valid_d = 1'b1;
                rsp_err_d   = merge_bad;
                rsp_rdata_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_count_d = err_count_q;
        if (rsp_valid_q && rsp_ready && rsp_err_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_count_q <= err_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ternary_mem_ctrl.sv
// tb/tb_ternary_mem_ctrl.sv - directed self-checking bench for ternary_mem_ctrl
module tb_ternary_mem_ctrl;
    import ternary_pkg::*;

    localparam int DEPTH = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_addr = '0;
    logic        req_we = 1'b0;
    logic [2:0]  req_tmask = '0;
    word_t       req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    word_t       rsp_rdata;
    logic        rsp_err;
    logic [7:0]  mem_addr;
    logic        mem_we, mem_re, mem_ce;
    word_t       mem_wdata;
    word_t       mem_rdata = '0;
    logic [15:0] err_count;

    word_t sram [256];
    int    cyc = 0;
    int    we_count = 0;
    int    ce_count = 0;
    int    checks = 0;
    int    failures = 0;

    ternary_mem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_tmask (req_tmask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_ce    (mem_ce),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_ce) begin
            ce_count <= ce_count + 1;
            if (mem_we) begin
                we_count <= we_count + 1;
                sram[mem_addr] <= mem_wdata;
            end
            if (mem_re) begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic word_t fill(input trit_t t);
        word_t w;
        for (int i = 0; i < DEF_TRIT_WIDTH; i++) w[i] = t;
        return w;
    endfunction

    task automatic send(input logic [7:0] addr, input logic we, input logic [2:0] tmask,
                        input word_t wdata, output int acc);
        req_addr  = addr;
        req_we    = we;
        req_tmask = tmask;
        req_wdata = wdata;
        req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check_eq("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input int acc, input int lat,
                              input logic err, input word_t data);
        int seen;
        seen = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = cyc;
                break;
            end
        end
        check_eq({tag, "_lat"}, 64'(seen - acc), 64'(lat));
        check_eq({tag, "_err"}, 64'(rsp_err), 64'(err));
        check_eq({tag, "_data"}, 64'(rsp_rdata), 64'(data));
        @(posedge clk);
        #1;
    endtask

    word_t a_word, b_word, bad_word;
    int    acc, we0, ce0;

    initial begin
        for (int i = 0; i < DEF_TRIT_WIDTH; i++) begin
            a_word[i] = (i % 3 == 0) ? T_POS_ONE : (i % 3 == 1) ? T_NEG_ONE : T_ZERO;
            b_word[i] = (i >= 9 && i <= 17) ? T_NEG_ONE : T_POS_ONE;
        end
        bad_word    = a_word;
        bad_word[3] = T_INVALID;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check_eq("rst_mem_ctl", 64'({mem_ce, mem_we, mem_re}), 64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_err_count", 64'(err_count), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // full-mask store then load
        send(8'd5, 1'b1, 3'b111, a_word, acc);
        expect_rsp("st5", acc, 1, 1'b0, '0);
        send(8'd5, 1'b0, 3'b000, '0, acc);
        expect_rsp("ld5", acc, 2, 1'b0, a_word);

        // back-to-back capable: ready stays up while the store response drains
        send(8'd9, 1'b1, 3'b111, fill(T_POS_ONE), acc);
        @(negedge clk);
        check_eq("b2b_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("b2b_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // masked read-modify-write of the middle tryte
        send(8'd7, 1'b1, 3'b111, fill(T_POS_ONE), acc);
        expect_rsp("st7", acc, 1, 1'b0, '0);
        we0 = we_count;
        send(8'd7, 1'b1, 3'b010, fill(T_NEG_ONE), acc);
        expect_rsp("rmw7", acc, 2, 1'b0, '0);
        check_eq("rmw7_writes", 64'(we_count - we0), 64'd1);
        send(8'd7, 1'b0, 3'b000, '0, acc);
        expect_rsp("ld7", acc, 2, 1'b0, b_word);

        // invalid trit in store data
        we0 = we_count;
        send(8'd5, 1'b1, 3'b111, bad_word, acc);
        expect_rsp("bad5", acc, 1, 1'b1, '0);
        check_eq("bad5_writes", 64'(we_count - we0), 64'd0);
        check_eq("bad5_err_count", 64'(err_count), 64'd1);
        send(8'd5, 1'b0, 3'b000, '0, acc);
        expect_rsp("ld5_kept", acc, 2, 1'b0, a_word);

        // out-of-range address and empty mask store: no SRAM access
        ce0 = ce_count;
        send(8'd255, 1'b0, 3'b000, '0, acc);
        expect_rsp("oor", acc, 1, 1'b1, '0);
        check_eq("oor_ce", 64'(ce_count - ce0), 64'd0);
        check_eq("oor_err_count", 64'(err_count), 64'd2);
        ce0 = ce_count;
        send(8'd5, 1'b1, 3'b000, fill(T_NEG_ONE), acc);
        expect_rsp("nomask", acc, 1, 1'b0, '0);
        check_eq("nomask_ce", 64'(ce_count - ce0), 64'd0);

        // response backpressure
        rsp_ready = 1'b0;
        send(8'd7, 1'b0, 3'b000, '0, acc);
        req_addr  = 8'd5;
        req_we    = 1'b0;
        req_tmask = 3'b000;
        req_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(rsp_valid), 64'd1);
            check_eq("hold_data", 64'(rsp_rdata), 64'(b_word));
            check_eq("hold_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("release_req_ready", 64'(req_ready), 64'd1);
        acc = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        expect_rsp("ld5_after_hold", acc, 2, 1'b0, a_word);

        // reset while a masked store is mid-flight
        we0 = we_count;
        send(8'd7, 1'b1, 3'b001, fill(T_ZERO), acc);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_writes", 64'(we_count - we0), 64'd0);
        check_eq("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("midrst_err_count", 64'(err_count), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'd7, 1'b0, 3'b000, '0, acc);
        expect_rsp("ld7_after_rst", acc, 2, 1'b0, b_word);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
